// File: rtl/lona_pkg.sv
// Shared types and command decode for the lona cover-motor drive stage.
package lona_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAD  = 3'd1,
        ST_CLOSE = 3'd2,
        ST_OPEN  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TG_NONE  = 2'd0,
        TG_CLOSE = 2'd1,
        TG_OPEN  = 2'd2
    } target_e;

    localparam logic [1:0] CMD_CLOSE = 2'b10;
    localparam logic [1:0] CMD_OPEN  = 2'b01;

    // Both-active and both-idle command pairs mean stop.
    function automatic target_e decode_cmd(input logic a, input logic b);
        target_e t;
        case ({a, b})
            CMD_CLOSE: t = TG_CLOSE;
            CMD_OPEN:  t = TG_OPEN;
            default:   t = TG_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lona_motor_seq_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] ff_d;
    logic [1:0] ff_q;

    // Shift the asynchronous level into the clock domain.
    always_comb begin
        ff_d = {ff_q[0], d};
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= 2'b00;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/lona_motor_seq.sv
// H-bridge sequencer: synchronised commands and end switches drive a dead-timed,
// timeout-guarded bridge FSM with a latched fault state.
module lona_motor_seq
    import lona_pkg::*;
#(
    parameter int DEAD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_a,
    input  logic cmd_b,
    input  logic fe,
    input  logic fd,
    input  logic fault_clr,
    output logic in1,
    output logic in2,
    output logic busy,
    output logic fault
);

    localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic s_a, s_b, s_fe, s_fd;
    target_e cmd_s;
    logic both_s, run_limit_s;
    target_e run_tg_s;

    state_e state_d, state_q;
    target_e target_d, target_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic in1_d, in1_q, in2_d, in2_q, busy_d, busy_q, fault_d, fault_q;

    sync2 u_sync_a  (.clk(clk), .rst_n(rst_n), .d(cmd_a), .q(s_a));
    sync2 u_sync_b  (.clk(clk), .rst_n(rst_n), .d(cmd_b), .q(s_b));
    sync2 u_sync_fe (.clk(clk), .rst_n(rst_n), .d(fe),    .q(s_fe));
    sync2 u_sync_fd (.clk(clk), .rst_n(rst_n), .d(fd),    .q(s_fd));

    // Next-state, target and shared dead/run counter logic.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        cmd_s       = decode_cmd(s_a, s_b);
        both_s      = s_fe & s_fd;
        run_tg_s    = (state_q == ST_CLOSE) ? TG_CLOSE : TG_OPEN;
        run_limit_s = (state_q == ST_CLOSE) ? s_fe : s_fd;

        if ((state_q != ST_FAULT) && both_s) begin
            state_d  = ST_FAULT;
            target_d = TG_NONE;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if ((cmd_s == TG_CLOSE) && !s_fe) begin
                        state_d  = ST_DEAD;
                        target_d = TG_CLOSE;
                    end else if ((cmd_s == TG_OPEN) && !s_fd) begin
                        state_d  = ST_DEAD;
                        target_d = TG_OPEN;
                    end else begin
                        target_d = TG_NONE;
                    end
                end
                ST_DEAD: begin
                    if (cmd_s != target_q) begin
                        target_d = cmd_s;
                        cnt_d    = '0;
                    end else if (cnt_q == DEAD_LAST) begin
                        cnt_d    = '0;
                        target_d = TG_NONE;
                        case (target_q)
                            TG_CLOSE: state_d = s_fe ? ST_IDLE : ST_CLOSE;
                            TG_OPEN:  state_d = s_fd ? ST_IDLE : ST_OPEN;
                            default:  state_d = ST_IDLE;
                        endcase
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_CLOSE, ST_OPEN: begin
                    // Limit switch outranks a command change, which outranks timeout.
                    if (run_limit_s) begin
                        state_d  = ST_DEAD;
                        target_d = TG_NONE;
                        cnt_d    = '0;
                    end else if (cmd_s != run_tg_s) begin
                        state_d  = ST_DEAD;
                        target_d = cmd_s;
                        cnt_d    = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d  = ST_FAULT;
                        target_d = TG_NONE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FAULT: begin
                    cnt_d = '0;
                    if (fault_clr && !both_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    target_d = TG_NONE;
                    cnt_d    = '0;
                end
            endcase
        end

        in1_d   = (state_d == ST_CLOSE);
        in2_d   = (state_d == ST_OPEN);
        busy_d  = (state_d == ST_DEAD) || (state_d == ST_CLOSE) || (state_d == ST_OPEN);
        fault_d = (state_d == ST_FAULT);
    end

    // State, counter and Moore outputs registered together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            target_q <= TG_NONE;
            cnt_q    <= '0;
            in1_q    <= 1'b0;
            in2_q    <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign in1   = in1_q;
    assign in2   = in2_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_lona_motor_seq.sv
// Directed scoreboard bench for lona_motor_seq with DEAD_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_lona_motor_seq;

    logic clk = 1'b0;
    logic rst_n, cmd_a, cmd_b, fe, fd, fault_clr;
    logic in1, in2, busy, fault;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } exp_t;

    exp_t sb_q[$];

    lona_motor_seq #(
        .DEAD_CYCLES(4),
        .TIMEOUT_CYCLES(20),
        .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .fe(fe), .fd(fd), .fault_clr(fault_clr),
        .in1(in1), .in2(in2), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected {in1,in2,busy,fault}.
    task automatic push(input string tag, input logic [3:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        logic [3:0] obs;
        obs = {in1, in2, busy, fault};
        n_checks++;
        assert (sb_q.size() > 0) else begin
            n_fails++;
            $error("FAIL sb_empty observed=%b expected=entry", obs);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            assert (obs === e.exp) else begin
                n_fails++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
        n_checks++;
        assert ((in1 & in2) === 1'b0) else begin
            n_fails++;
            $error("FAIL bridge_short observed=%b%b expected=not 11", in1, in2);
        end
    endtask

    task automatic step(input string tag, input int n, input logic [3:0] exp);
        push(tag, exp);
        tick(n);
        pop_check();
    endtask

    initial begin
        rst_n = 1'b1; cmd_a = 1'b0; cmd_b = 1'b0;
        fe = 1'b0; fd = 1'b0; fault_clr = 1'b0;
        #1 rst_n = 1'b0;
        push("reset", 4'b0000);
        #2 pop_check();
        tick(2);
        rst_n = 1'b1;

        // Close from idle: busy after 3 edges, drive on the 7th.
        cmd_a = 1'b1;
        step("s1_sync", 2, 4'b0000);
        step("s1_dead", 1, 4'b0010);
        step("s1_dead_end", 3, 4'b0010);
        step("s1_close", 1, 4'b1010);

        // Left limit switch ends the close run.
        fe = 1'b1; cmd_a = 1'b0;
        step("s2_pre", 2, 4'b1010);
        step("s2_dead", 1, 4'b0010);
        step("s2_dead_end", 3, 4'b0010);
        step("s2_idle", 1, 4'b0000);
        fe = 1'b0;

        // Open, then reverse to close with four off cycles.
        cmd_b = 1'b1;
        step("s3_open", 7, 4'b0110);
        cmd_b = 1'b0; cmd_a = 1'b1;
        step("s3_pre", 2, 4'b0110);
        for (int i = 0; i < 4; i++) step("s3_dead", 1, 4'b0010);
        step("s3_close", 1, 4'b1010);

        // Timeout: 20 energised cycles in total, then fault.
        for (int i = 0; i < 19; i++) step("s4_run", 1, 4'b1010);
        step("s4_timeout", 1, 4'b0001);
        fault_clr = 1'b1;
        step("s4_clr", 1, 4'b0000);
        fault_clr = 1'b0;
        step("s4_redead", 1, 4'b0010);
        step("s4_redead_end", 3, 4'b0010);
        step("s4_reclose", 1, 4'b1010);

        // Impossible switch state during open.
        cmd_a = 1'b0; cmd_b = 1'b1;
        step("s5_pre", 2, 4'b1010);
        step("s5_dead", 1, 4'b0010);
        step("s5_dead_end", 3, 4'b0010);
        step("s5_open", 1, 4'b0110);
        fe = 1'b1; fd = 1'b1;
        step("s5_sync", 2, 4'b0110);
        step("s5_fault", 1, 4'b0001);
        fault_clr = 1'b1;
        step("s5_hold", 3, 4'b0001);
        fd = 1'b0; cmd_b = 1'b0;
        step("s5_hold2", 2, 4'b0001);
        step("s5_release", 1, 4'b0000);
        fault_clr = 1'b0; fe = 1'b0;
        step("s5_idle", 3, 4'b0000);

        // Both commands active means stop.
        cmd_a = 1'b1; cmd_b = 1'b1;
        step("s6_both", 5, 4'b0000);
        cmd_b = 1'b0;
        step("s6_sync", 2, 4'b0000);
        step("s6_dead", 1, 4'b0010);
        step("s6_close", 4, 4'b1010);
        step("s6_run", 3, 4'b1010);

        // Asynchronous reset mid-run, then a full restart.
        rst_n = 1'b0;
        push("s6_rst_async", 4'b0000);
        #1 pop_check();
        tick(1);
        rst_n = 1'b1;
        step("s6_post_sync", 2, 4'b0000);
        step("s6_restart", 1, 4'b0010);

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fails++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
